pipe_tx_framer: RTL and testbench

- Transmit-side framing stage that sits directly upstream of the PHY and drives its MAC_TX_Data / MAC_TX_DataK / MAC_Data_En inputs.
- Takes a word stream from the link layer over a valid/ready handshake.
- On enable, emits a COM alignment burst first, then passes data through.
- Fills gaps with idle words and periodically inserts SKP ordered sets (COM + 3×SKP), sized to the active DataBusWidth (8/16/32).

---
 rtl/pipe_tx_framer_if.sv | 23 ++
 rtl/pipe_tx_framer.sv | 205 ++++++++++++++++++++
 tb/tb_pipe_tx_framer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_tx_framer_if.sv
// Link-layer word stream and PHY-side symbol bus of the PIPE transmit framer.
interface pipe_tx_framer_if;
  logic [5:0]  DataBusWidth;
  logic        tx_enable;
  logic [31:0] in_data;
  logic [3:0]  in_datak;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] MAC_TX_Data;
  logic [3:0]  MAC_TX_DataK;
  logic        MAC_Data_En;
  logic        link_aligned;

  modport master (
    output DataBusWidth, tx_enable, in_data, in_datak, in_valid,
    input  in_ready, MAC_TX_Data, MAC_TX_DataK, MAC_Data_En, link_aligned
  );

  modport slave (
    input  DataBusWidth, tx_enable, in_data, in_datak, in_valid,
    output in_ready, MAC_TX_Data, MAC_TX_DataK, MAC_Data_En, link_aligned
  );
endinterface

// File: rtl/pipe_tx_framer.sv
// PIPE transmit framer: COM alignment burst on enable, idle fill, data passthrough.
// Define SKP_INSERT_EN to build in periodic SKP ordered-set insertion (default: ALIGN -> RUN only).
module pipe_tx_framer #(
  parameter int ALIGN_SYMBOLS = 16,
  parameter int SKP_INTERVAL  = 1180
) (
  input logic             PCLK,
  input logic             Reset_n,
  pipe_tx_framer_if.slave bus
);
  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [1:0] W8  = 2'd0;
  localparam logic [1:0] W16 = 2'd1;
  localparam logic [1:0] W32 = 2'd2;
  // One width serves both the alignment and SKP counters.
  localparam int CNT_MAX = (ALIGN_SYMBOLS > SKP_INTERVAL) ? ALIGN_SYMBOLS : SKP_INTERVAL;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] ALIGN_LAST_N1 = CNT_W'(ALIGN_SYMBOLS - 1);
  localparam logic [CNT_W-1:0] ALIGN_LAST_N2 = CNT_W'(ALIGN_SYMBOLS / 2 - 1);
  localparam logic [CNT_W-1:0] ALIGN_LAST_N4 = CNT_W'(ALIGN_SYMBOLS / 4 - 1);

`ifdef SKP_INSERT_EN
  localparam logic [7:0]       SKP_SYM  = 8'h1C;
  localparam logic [CNT_W-1:0] SKP_LAST = CNT_W'(SKP_INTERVAL - 1);
  typedef enum logic [1:0] {IDLE, ALIGN, RUN, SKP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;
`endif

  state_t           state_reg, state_next;
  logic [1:0]       width_reg;
  logic [1:0]       width_sel;
  logic [CNT_W-1:0] align_cnt_reg, align_cnt_next;
  logic [CNT_W-1:0] align_last;
  logic [31:0]      data_reg, data_next;
  logic [3:0]       datak_reg, datak_next;
  logic             en_reg, en_next;
  logic [3:0]       lane_mask;
  logic [31:0]      pass_data;
  logic [31:0]      com_data;
  logic             ready;

`ifdef SKP_INSERT_EN
  logic [CNT_W-1:0] skp_cnt_reg, skp_cnt_next;
  logic [1:0]       skp_idx_reg, skp_idx_next;
  logic [1:0]       skp_last_idx;
  logic             skp_due;
  logic             skp_last;
  logic             skp_lead;
  logic [31:0]      skp_data;
`endif

  // Width follows the input while idle and freezes on the edge that leaves IDLE.
  assign width_sel = (state_reg != IDLE) ? width_reg :
                     (bus.DataBusWidth == 6'd32) ? W32 :
                     (bus.DataBusWidth == 6'd16) ? W16 : W8;

  assign align_last = (width_sel == W32) ? ALIGN_LAST_N4 :
                      (width_sel == W16) ? ALIGN_LAST_N2 : ALIGN_LAST_N1;

`ifdef SKP_INSERT_EN
  assign skp_last_idx = (width_reg == W32) ? 2'd0 : (width_reg == W16) ? 2'd1 : 2'd3;
  assign skp_due      = (state_reg == RUN) && (skp_cnt_reg == SKP_LAST);
  assign skp_last     = (state_reg == SKP) && (skp_idx_reg == skp_last_idx);
  // Only the very first symbol of a set is COM, and it always lands on lane 0.
  assign skp_lead     = (state_reg != SKP);
  assign ready        = bus.tx_enable && (((state_reg == RUN) && !skp_due) || skp_last);
  assign bus.link_aligned = (state_reg == RUN) || (state_reg == SKP);
`else
  assign ready        = bus.tx_enable && (state_reg == RUN);
  assign bus.link_aligned = (state_reg == RUN);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] MIN_CODE = (gi == 0) ? W8 : ((gi == 1) ? W16 : W32);
      assign lane_mask[gi]          = (width_sel >= MIN_CODE);
      assign pass_data[8*gi +: 8]   = lane_mask[gi] ? bus.in_data[8*gi +: 8] : 8'h00;
      assign com_data[8*gi +: 8]    = lane_mask[gi] ? COM_SYM : 8'h00;
`ifdef SKP_INSERT_EN
      assign skp_data[8*gi +: 8]    = !lane_mask[gi] ? 8'h00 :
                                      ((gi == 0) && skp_lead) ? COM_SYM : SKP_SYM;
`endif
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    align_cnt_next = align_cnt_reg;
    data_next      = 32'h0;
    datak_next     = 4'h0;
    en_next        = 1'b0;
`ifdef SKP_INSERT_EN
    skp_cnt_next   = skp_cnt_reg;
    skp_idx_next   = skp_idx_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.tx_enable) begin
          state_next     = ALIGN;
          align_cnt_next = '0;
          data_next      = com_data;
          datak_next     = lane_mask;
          en_next        = 1'b1;
        end
      end
      ALIGN: begin
        if (!bus.tx_enable) begin
          state_next = IDLE;
        end else if (align_cnt_reg == align_last) begin
          state_next = RUN;
          en_next    = 1'b1;
`ifdef SKP_INSERT_EN
          skp_cnt_next = '0;
`endif
        end else begin
          align_cnt_next = align_cnt_reg + CNT_W'(1);
          data_next      = com_data;
          datak_next     = lane_mask;
          en_next        = 1'b1;
        end
      end
      RUN: begin
        if (!bus.tx_enable) begin
          state_next = IDLE;
`ifdef SKP_INSERT_EN
        end else if (skp_due) begin
          state_next   = SKP;
          skp_cnt_next = '0;
          skp_idx_next = 2'd0;
          data_next    = skp_data;
          datak_next   = lane_mask;
          en_next      = 1'b1;
`endif
        end else begin
          en_next = 1'b1;
`ifdef SKP_INSERT_EN
          skp_cnt_next = skp_cnt_reg + CNT_W'(1);
`endif
          if (ready && bus.in_valid) begin
            data_next  = pass_data;
            datak_next = bus.in_datak & lane_mask;
          end
        end
      end
`ifdef SKP_INSERT_EN
      SKP: begin
        skp_cnt_next = skp_cnt_reg + CNT_W'(1);
        if (skp_last) begin
          // A set in flight always completes; enable is only honoured at its end.
          if (!bus.tx_enable) begin
            state_next = IDLE;
          end else begin
            state_next = RUN;
            en_next    = 1'b1;
            if (ready && bus.in_valid) begin
              data_next  = pass_data;
              datak_next = bus.in_datak & lane_mask;
            end
          end
        end else begin
          skp_idx_next = skp_idx_reg + 2'd1;
          data_next    = skp_data;
          datak_next   = lane_mask;
          en_next      = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= IDLE;
      width_reg     <= W8;
      align_cnt_reg <= '0;
      data_reg      <= 32'h0;
      datak_reg     <= 4'h0;
      en_reg        <= 1'b0;
`ifdef SKP_INSERT_EN
      skp_cnt_reg   <= '0;
      skp_idx_reg   <= 2'd0;
`endif
    end else begin
      state_reg     <= state_next;
      width_reg     <= width_sel;
      align_cnt_reg <= align_cnt_next;
      data_reg      <= data_next;
      datak_reg     <= datak_next;
      en_reg        <= en_next;
`ifdef SKP_INSERT_EN
      skp_cnt_reg   <= skp_cnt_next;
      skp_idx_reg   <= skp_idx_next;
`endif
    end
  end

  assign bus.in_ready     = ready;
  assign bus.MAC_TX_Data  = data_reg;
  assign bus.MAC_TX_DataK = datak_reg;
  assign bus.MAC_Data_En  = en_reg;

endmodule

// File: tb/tb_pipe_tx_framer.sv
// Scoreboard bench for pipe_tx_framer: expected PHY words queued at drive time, compared after each PCLK edge.
module tb_pipe_tx_framer;
  localparam int ALIGN_SYMBOLS = 16;
  localparam int SKP_INTERVAL  = 8;
`ifdef SKP_INSERT_EN
  localparam bit SKP_ON = 1'b1;
`else
  localparam bit SKP_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_tx_framer_if bus();

  pipe_tx_framer #(
    .ALIGN_SYMBOLS(ALIGN_SYMBOLS),
    .SKP_INTERVAL (SKP_INTERVAL)
  ) dut (
    .PCLK   (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  k;
    logic        en;
    logic        al;
    logic        rdy;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic [3:0] k,
                              input logic en, input logic al, input logic rdy);
    exp_t e;
    e.data = d; e.k = k; e.en = en; e.al = al; e.rdy = rdy;
    return e;
  endfunction

  // Drive inputs for the coming edge and queue what the PHY side must show after it.
  task automatic cyc(input string tag, input logic te, input logic [5:0] dbw, input logic v,
                     input logic [31:0] d, input logic [3:0] dk, input exp_t e);
    @(negedge clk);
    bus.tx_enable    = te;
    bus.DataBusWidth = dbw;
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.in_datak     = dk;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t  e;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".data"}, bus.MAC_TX_Data, e.data);
      check({t, ".k"},    32'(bus.MAC_TX_DataK), 32'(e.k));
      check({t, ".en"},   32'(bus.MAC_Data_En), 32'(e.en));
      check({t, ".al"},   32'(bus.link_aligned), 32'(e.al));
      check({t, ".rdy"},  32'(bus.in_ready), 32'(e.rdy));
      $display("txn %-12s data=%08h k=%b en=%b al=%b rdy=%b", t, bus.MAC_TX_Data,
               bus.MAC_TX_DataK, bus.MAC_Data_En, bus.link_aligned, bus.in_ready);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cur;
    bit         prev_rdy;
    int         n_run;
    exp_t       zero;
    zero = mk(32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    bus.tx_enable    = 1'b0;
    bus.DataBusWidth = 6'd32;
    bus.in_valid     = 1'b0;
    bus.in_data      = 32'h0;
    bus.in_datak     = 4'h0;

    // Reset state, then stay quiet with enable low.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rst.data", bus.MAC_TX_Data, 32'h0);
    check("rst.k",    32'(bus.MAC_TX_DataK), 32'h0);
    check("rst.en",   32'(bus.MAC_Data_En), 32'h0);
    check("rst.rdy",  32'(bus.in_ready), 32'h0);
    check("rst.al",   32'(bus.link_aligned), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc("idle", 1'b0, 6'd32, 1'b0, 32'h0, 4'h0, zero);

    // 32-bit alignment burst: 16 COM symbols over 4 words.
    for (int i = 0; i < 4; i++)
      cyc("align32", 1'b1, 6'd32, 1'b0, 32'h0, 4'h0, mk(32'hBCBCBCBC, 4'hF, 1'b1, 1'b0, 1'b0));
    cyc("run32_idle0", 1'b1, 6'd32, 1'b0, 32'h0, 4'h0, mk(32'h0, 4'h0, 1'b1, 1'b1, 1'b1));
    cyc("run32_idle1", 1'b1, 6'd32, 1'b0, 32'h0, 4'h0, mk(32'h0, 4'h0, 1'b1, 1'b1, 1'b1));
    cyc("disable32",   1'b0, 6'd32, 1'b0, 32'h0, 4'h0, zero);
    #1;
    check("rdy_drop", 32'(bus.in_ready), 32'h0);

    // 16-bit passthrough; upper lanes of in_data/in_datak carry junk that must not appear.
    for (int i = 0; i < 8; i++)
      cyc("align16", 1'b1, 6'd16, 1'b1, 32'hDEAD1234, 4'hC, mk(32'h0000BCBC, 4'h3, 1'b1, 1'b0, 1'b0));
    cyc("run16_idle", 1'b1, 6'd16, 1'b1, 32'hDEAD1234, 4'hC, mk(32'h0, 4'h0, 1'b1, 1'b1, 1'b1));
    cyc("run16_w0",   1'b1, 6'd16, 1'b1, 32'hDEAD1234, 4'hC, mk(32'h00001234, 4'h0, 1'b1, 1'b1, 1'b1));
    cyc("run16_w1",   1'b1, 6'd16, 1'b1, 32'h5A5AABCD, 4'hE, mk(32'h0000ABCD, 4'h2, 1'b1, 1'b1, 1'b1));
    cyc("run16_gap",  1'b1, 6'd16, 1'b0, 32'h0, 4'h0, mk(32'h0, 4'h0, 1'b1, 1'b1, 1'b1));
    cyc("disable16",  1'b0, 6'd16, 1'b0, 32'h0, 4'h0, zero);

    // 8-bit continuous stream; SKP sets start every SKP_INTERVAL cycles after RUN entry.
    cur = 8'h40;
    prev_rdy = 1'b0;
    for (int i = 0; i < 16; i++)
      cyc("align8", 1'b1, 6'd8, 1'b1, {24'hFFFFFF, cur}, 4'hE, mk(32'h000000BC, 4'h1, 1'b1, 1'b0, 1'b0));
    n_run = SKP_ON ? 34 : 16;
    for (int t = 0; t < n_run; t++) begin
      int          u;
      bit          in_skp;
      bit          rdy_t;
      logic [31:0] ed;
      logic [3:0]  ek;
      u      = (t - SKP_INTERVAL) % SKP_INTERVAL;
      in_skp = SKP_ON && (t >= SKP_INTERVAL) && (u < 4);
      if (!SKP_ON)                rdy_t = 1'b1;
      else if (in_skp)            rdy_t = (u == 3);
      else if (t < SKP_INTERVAL)  rdy_t = (t != SKP_INTERVAL - 1);
      else                        rdy_t = (u != SKP_INTERVAL - 1);
      if (in_skp) begin
        ed = (u == 0) ? 32'h000000BC : 32'h0000001C;
        ek = 4'h1;
      end else if (prev_rdy) begin
        ed = {24'h0, cur};
        ek = 4'h0;
      end else begin
        ed = 32'h0;
        ek = 4'h0;
      end
      cyc(in_skp ? "skp8" : "run8", 1'b1, 6'd8, 1'b1, {24'hFFFFFF, cur}, 4'hE,
          mk(ed, ek, 1'b1, 1'b1, rdy_t));
      if (prev_rdy) cur = cur + 8'd1;
      prev_rdy = rdy_t;
    end
`ifdef SKP_INSERT_EN
    // Enable falls while the second SKP symbol is on the bus: the set still completes.
    cyc("skp8_sym3", 1'b0, 6'd8, 1'b1, {24'hFFFFFF, cur}, 4'hE, mk(32'h0000001C, 4'h1, 1'b1, 1'b1, 1'b0));
    cyc("skp8_sym4", 1'b0, 6'd8, 1'b1, {24'hFFFFFF, cur}, 4'hE, mk(32'h0000001C, 4'h1, 1'b1, 1'b1, 1'b0));
    cyc("skp8_off",  1'b0, 6'd8, 1'b0, 32'h0, 4'h0, zero);
`else
    cyc("run8_off",  1'b0, 6'd8, 1'b0, 32'h0, 4'h0, zero);
`endif

    // Asynchronous reset mid-stream, then a full re-alignment.
    for (int i = 0; i < 4; i++)
      cyc("align32b", 1'b1, 6'd32, 1'b0, 32'h0, 4'h0, mk(32'hBCBCBCBC, 4'hF, 1'b1, 1'b0, 1'b0));
    cyc("run32b_idle", 1'b1, 6'd32, 1'b1, 32'h11223344, 4'h5, mk(32'h0, 4'h0, 1'b1, 1'b1, 1'b1));
    cyc("run32b_w",    1'b1, 6'd32, 1'b1, 32'h11223344, 4'h5, mk(32'h11223344, 4'h5, 1'b1, 1'b1, 1'b1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.data", bus.MAC_TX_Data, 32'h0);
    check("arst.k",    32'(bus.MAC_TX_DataK), 32'h0);
    check("arst.en",   32'(bus.MAC_Data_En), 32'h0);
    check("arst.rdy",  32'(bus.in_ready), 32'h0);
    check("arst.al",   32'(bus.link_aligned), 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc("realign32", 1'b1, 6'd32, 1'b0, 32'h0, 4'h0, mk(32'hBCBCBCBC, 4'hF, 1'b1, 1'b0, 1'b0));
    cyc("realign_run", 1'b1, 6'd32, 1'b0, 32'h0, 4'h0, mk(32'h0, 4'h0, 1'b1, 1'b1, 1'b1));
    cyc("final_off",   1'b0, 6'd32, 1'b0, 32'h0, 4'h0, zero);

    @(posedge clk);
    #3;
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
